// File: rtl/dnn_pkg.sv
// Shared types and constants for the detection NN arbiter.
// The state enum, lane-count default and retire counter width live here.
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } det_arb_state;

    localparam int DET_ARB_NUM_REQ = 4;
    localparam int RETIRE_CNT_W    = 16;

endpackage

// File: rtl/det_nn_rr_pick.sv
// Rotate-priority search: the first pending lane at or after last_owner+1 wins.
module det_nn_rr_pick
    import dnn_pkg::*;
#(
    parameter int NUM_REQ = DET_ARB_NUM_REQ,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [SEL_W-1:0]   last_owner,
    output logic               valid,
    output logic [SEL_W-1:0]   winner
);

    int         idx;
    logic [SEL_W-1:0] idx_w;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = (int'(last_owner) + i) % NUM_REQ;
            idx_w = SEL_W'(idx);
            if (!valid && pending[idx_w]) begin
                valid  = 1'b1;
                winner = idx_w;
            end
        end
    end

endmodule

// File: rtl/det_nn_arbiter.sv
// Round-robin time-sharing of one detection NN core between NUM_REQ lanes,
// with a watchdog that force-retires a request when the core stalls.
//
// state | meaning
// IDLE  | no request in flight; grant the next pending lane if any
// ISSUE | nn_start asserted for this single cycle
// WAIT  | waiting for nn_done or watchdog expiry
module det_nn_arbiter
    import dnn_pkg::*;
#(
    parameter int NUM_REQ        = DET_ARB_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_start,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       req_result,
    output logic                       nn_start,
    output logic [$clog2(NUM_REQ)-1:0] nn_sel,
    input  logic                       nn_done,
    input  logic                       nn_result,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       spurious_err,
    input  logic                       err_clr,
    output logic [RETIRE_CNT_W-1:0]    retire_cnt
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    det_arb_state              state_q, state_d;
    logic [NUM_REQ-1:0]        pending_q, pending_d;
    logic [SEL_W-1:0]          last_owner_q, last_owner_d;
    logic [SEL_W-1:0]          owner_q, owner_d;
    logic [WD_W-1:0]           wd_cnt_q, wd_cnt_d;
    logic [RETIRE_CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      spurious_err_q, spurious_err_d;
    logic                      nn_start_q, nn_start_d;
    logic                      busy_q, busy_d;

    logic                      pick_valid;
    logic [SEL_W-1:0]          pick_winner;
    logic                      grant;
    logic                      wd_expire;
    logic                      retire;
    logic                      timeout_new;
    logic                      spurious_new;
    logic [NUM_REQ-1:0]        pending_clr;

    det_nn_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .pending    (pending_q),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        owner_d        = owner_q;
        wd_cnt_d       = wd_cnt_q;
        retire_cnt_d   = retire_cnt_q;
        nn_start_d     = 1'b0;

        grant        = (state_q == IDLE) && pick_valid;
        wd_expire    = (state_q == WAIT) && (wd_cnt_q == WD_LAST);
        retire       = (state_q == WAIT) && (nn_done || wd_expire);
        timeout_new  = wd_expire && !nn_done;
        spurious_new = nn_done && (state_q != WAIT);

        // A request arriving on the lane being granted stays pending.
        pending_clr = grant ? (NUM_REQ'(1) << pick_winner) : '0;
        pending_d   = (pending_q & ~pending_clr) | req_start;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d    = pick_winner;
                    nn_start_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wd_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (retire) begin
                    last_owner_d = owner_q;
                    retire_cnt_d = retire_cnt_q + RETIRE_CNT_W'(1);
                    state_d      = IDLE;
                end else if (wd_cnt_q != WD_LAST) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d         = (state_d == ISSUE) || (state_d == WAIT);
        timeout_err_d  = (timeout_err_q & ~err_clr) | timeout_new;
        spurious_err_d = (spurious_err_q & ~err_clr) | spurious_new;

        req_done   = retire ? (NUM_REQ'(1) << owner_q) : '0;
        req_result = retire && nn_done && nn_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            last_owner_q   <= SEL_W'(NUM_REQ - 1);
            owner_q        <= '0;
            wd_cnt_q       <= '0;
            retire_cnt_q   <= '0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
            nn_start_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            last_owner_q   <= last_owner_d;
            owner_q        <= owner_d;
            wd_cnt_q       <= wd_cnt_d;
            retire_cnt_q   <= retire_cnt_d;
            timeout_err_q  <= timeout_err_d;
            spurious_err_q <= spurious_err_d;
            nn_start_q     <= nn_start_d;
            busy_q         <= busy_d;
        end
    end

    assign nn_start     = nn_start_q;
    assign nn_sel       = owner_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign spurious_err = spurious_err_q;
    assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_det_nn_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared cycle by cycle against a behavioural model of the arbiter.
module tb_det_nn_arbiter;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int NEVER = 1000;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_start;
    logic [N-1:0]  req_done;
    logic          req_result;
    logic          nn_start;
    logic [1:0]    nn_sel;
    logic          nn_done;
    logic          nn_result;
    logic          busy;
    logic          timeout_err;
    logic          spurious_err;
    logic          err_clr;
    logic [15:0]   retire_cnt;

    det_nn_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_start    (req_start),
        .req_done     (req_done),
        .req_result   (req_result),
        .nn_start     (nn_start),
        .nn_sel       (nn_sel),
        .nn_done      (nn_done),
        .nn_result    (nn_result),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .spurious_err (spurious_err),
        .err_clr      (err_clr),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Model: phase 0 = free, 1 = start cycle, 2 = core working.
    bit [N-1:0] m_pend;
    int         m_last, m_phase, m_sel, m_wd, m_lat, m_retire;
    bit         m_terr, m_serr;
    int         lat_force = -1;

    function automatic int rr_winner(input bit [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_last = N - 1; m_phase = 0; m_sel = 0;
        m_wd = 0; m_lat = NEVER; m_retire = 0; m_terr = 0; m_serr = 0;
    endtask

    task automatic model_check(input bit nd, input bit nr);
        bit [N-1:0] e_done;
        bit         fin;
        fin    = (m_phase == 2) && (nd || m_wd == T - 1);
        e_done = fin ? (N'(1) << m_sel) : '0;
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("nn_start", 32'(nn_start), 32'(m_phase == 1));
        chk("nn_sel", 32'(nn_sel), 32'(m_sel));
        chk("req_done", 32'(req_done), 32'(e_done));
        if (fin) chk("req_result", 32'(req_result), 32'(nd && nr));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("spurious_err", 32'(spurious_err), 32'(m_serr));
        chk("retire_cnt", 32'(retire_cnt), 32'(m_retire));
    endtask

    task automatic model_advance(input bit [N-1:0] rs, input bit nd, input bit ec);
        int         w;
        int         r;
        bit         terr_new, serr_new;
        bit [N-1:0] np;
        w        = (m_phase == 0) ? rr_winner(m_pend, m_last) : -1;
        terr_new = 0;
        serr_new = nd && (m_phase != 2);
        np       = m_pend;
        if (w >= 0) np[w] = 1'b0;
        np = np | rs;
        case (m_phase)
            0: if (w >= 0) begin m_sel = w; m_phase = 1; end
            1: begin
                m_phase = 2; m_wd = 0;
                if (lat_force >= 0) m_lat = lat_force;
                else begin
                    r = $urandom_range(0, 9);
                    if (r < 6)      m_lat = $urandom_range(0, 8);
                    else if (r < 8) m_lat = T - 1;
                    else            m_lat = NEVER;
                end
            end
            default: begin
                if (nd || m_wd == T - 1) begin
                    terr_new = !nd;
                    m_retire = (m_retire + 1) % 65536;
                    m_last   = m_sel;
                    m_phase  = 0;
                end else m_wd++;
            end
        endcase
        m_pend = np;
        m_terr = (m_terr && !ec) || terr_new;
        m_serr = (m_serr && !ec) || serr_new;
    endtask

    // One clock: drive after the edge, check and advance the model at the falling edge.
    task automatic run_cycle(input bit [N-1:0] rs, input bit stray, input bit ec, input bit rb);
        bit nd, nr;
        @(posedge clk);
        #1;
        if (!rb) model_reset();
        nd = rb && (((m_phase == 2) && (m_wd == m_lat)) || stray);
        nr = 1'($urandom_range(0, 1));
        rst_n = rb; req_start = rb ? rs : '0; nn_done = nd; nn_result = nr; err_clr = ec;
        @(negedge clk);
        model_check(nd, nr);
        if (rb) model_advance(rb ? rs : '0, nd, ec);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle('0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req_start = '0; nn_done = 1'b0; nn_result = 1'b0; err_clr = 1'b0;
        model_reset();
        run_cycle('0, 1'b0, 1'b0, 1'b0);
        run_cycle('0, 1'b0, 1'b0, 1'b0);

        // Single request on lane 2, core answers 20 cycles after nn_start.
        lat_force = 19;
        idle(8);
        run_cycle(4'b0100, 1'b0, 1'b0, 1'b1);
        idle(30);

        // Watchdog on a silent core, then clear and a normal request.
        lat_force = NEVER;
        run_cycle(4'b0010, 1'b0, 1'b0, 1'b1);
        idle(T + 6);
        run_cycle('0, 1'b0, 1'b1, 1'b1);
        lat_force = 3;
        run_cycle(4'b0010, 1'b0, 1'b0, 1'b1);
        idle(10);

        // nn_done on the expiry cycle, then a stray nn_done while idle.
        lat_force = T - 1;
        run_cycle(4'b1000, 1'b0, 1'b0, 1'b1);
        idle(T + 6);
        run_cycle('0, 1'b1, 1'b0, 1'b1);
        idle(2);
        run_cycle('0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Lane 0 re-pulses on the cycle it is granted.
        lat_force = 2;
        run_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        run_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        idle(16);

        // Contention with immediate re-requests.
        lat_force = 4;
        run_cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) run_cycle(req_done, 1'b0, 1'b0, 1'b1);
        idle(12);

        // Reset in the middle of WAIT, then everyone requests.
        lat_force = NEVER;
        run_cycle(4'b0100, 1'b0, 1'b0, 1'b1);
        idle(6);
        run_cycle('0, 1'b0, 1'b0, 1'b0);
        lat_force = 1;
        run_cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        idle(30);

        // Random traffic.
        lat_force = -1;
        for (int i = 0; i < 4000; i++) begin
            bit [N-1:0] rs;
            for (int b = 0; b < N; b++) rs[b] = ($urandom_range(0, 5) == 0);
            run_cycle(rs,
                      (m_phase != 2) && ($urandom_range(0, 39) == 0),
                      $urandom_range(0, 29) == 0,
                      $urandom_range(0, 599) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
